board_frame_uart_tx: RTL

- Parametrised successor to the fixed single-shot board-string UART sender.
- Captures a DATA_W-bit board vector on a start request and transmits it as one framed 8N1 UART packet: sync byte, length byte, payload bytes LSB-first, optional checksum.
- Sits between the pixel analyzer's board string and the board's tx pin.
- Replaces the direct wide-vector-into-UART hookup with a byte sequencer, a busy/done handshake and overrun reporting.

---
 rtl/board_link_pkg.sv | 31 +++
 rtl/uart_byte_tx.sv | 88 ++++++++
 rtl/board_frame_uart_tx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/board_link_pkg.sv
// -----------------------------------------------------------------------------
// board_link_pkg
// Shared framing definitions for the board-string UART link.
//   - SYNC_DEFAULT     : default first byte of every frame
//   - UART_FRAME_BITS  : bits per 8N1 character (start + 8 data + stop)
//   - frame_state_e    : frame sequencer states
//   - calcNbytes()     : payload byte count for a given payload width
// Optional feature macro: FRAME_CHECKSUM_EN adds the CSUM state.
// -----------------------------------------------------------------------------
package board_link_pkg;

    localparam logic [7:0] SYNC_DEFAULT    = 8'hA5;
    localparam int         UART_FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LEN,
        ST_PAYLOAD,
`ifdef FRAME_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_FINISH
    } frame_state_e;

    // Number of whole bytes needed to carry dataW bits (last byte zero padded).
    function automatic int calcNbytes(input int dataW);
        return (dataW + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// 8N1 byte serialiser, LSB first, CLKS_PER_BIT clocks per bit.
// A byte offered on the final cycle of a stop bit is loaded on that same edge,
// so consecutive bytes follow each other with no idle gap.
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   byte_valid_i  load byte_i (taken when ready_o is high)
//   byte_i        byte to send
//   ready_o       engine idle or finishing its stop bit this cycle
//   byte_done_o   strobe on the last cycle of the stop bit
//   tx_o          serial line, idle high
// -----------------------------------------------------------------------------
module uart_byte_tx
    import board_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_i,
    output logic       ready_o,
    output logic       byte_done_o,
    output logic       tx_o
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        BIT_LAST = 4'(UART_FRAME_BITS - 1);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bitIdx_q, bitIdx_d;
    logic [9:0]       shift_q, shift_d;
    logic             bitEnd;

    // The shift register holds the whole character including start and stop
    // bits, so the line is simply its LSB while a character is in flight.
    assign bitEnd      = active_q && (cnt_q == CNT_LAST);
    assign byte_done_o = bitEnd && (bitIdx_q == BIT_LAST);
    assign ready_o     = !active_q || byte_done_o;
    assign tx_o        = active_q ? shift_q[0] : 1'b1;

    // Bit timing: count clocks within a bit, shift on each bit boundary, and
    // either reload or go idle when the stop bit finishes.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        if (active_q) begin
            if (bitEnd) begin
                cnt_d    = '0;
                shift_d  = {1'b1, shift_q[9:1]};
                bitIdx_d = bitIdx_q + 4'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (byte_done_o) begin
            active_d = 1'b0;
        end
        if (byte_valid_i && ready_o) begin
            active_d = 1'b1;
            cnt_d    = '0;
            bitIdx_d = '0;
            shift_d  = {1'b1, byte_i, 1'b0};
        end
    end

    // Engine state register; reset drops any character in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= '1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
        end
    end

endmodule

// File: rtl/board_frame_uart_tx.sv
// -----------------------------------------------------------------------------
// board_frame_uart_tx
// Captures a DATA_W-bit board vector on start and sends it as one UART frame:
// SYNC_BYTE, length byte, payload bytes LSB-first, optional XOR checksum.
// Ports:
//   clk      clock (25 MHz VGA domain)
//   rst_n    asynchronous active-low reset
//   start    frame request
//   data     board vector, captured when start is accepted
//   busy     frame in flight
//   done     one-cycle pulse at end of frame
//   overrun  one-cycle pulse after a start seen while busy
//   tx       UART serial out, idle high
// Optional feature macro: FRAME_CHECKSUM_EN appends the checksum byte.
// -----------------------------------------------------------------------------
module board_frame_uart_tx
    import board_link_pkg::*;
#(
    parameter int         DATA_W       = 188,
    parameter int         CLKS_PER_BIT = 217,
    parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic              tx
);

    localparam int               NBYTES   = calcNbytes(DATA_W);
    localparam int               IDX_W    = $clog2(NBYTES + 1);
    localparam int               PAD_W    = (NBYTES + 1) * 8;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
    localparam logic [7:0]       LEN_BYTE = 8'(NBYTES);

    frame_state_e      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, nxtIdx;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic              overrun_q;
    logic [PAD_W-1:0]  padded;
    logic [7:0]        nxtPayload;
    logic              wantByte, byteValid, engReady, byteDone;
    logic [7:0]        txByte;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    // One spare zero byte above the payload keeps the look-ahead select in
    // range when the index sits on the last payload byte.
    assign padded     = PAD_W'(shadow_q);
    assign nxtIdx     = idx_q + 1'b1;
    assign nxtPayload = padded[nxtIdx*8 +: 8];
    assign byteValid  = wantByte && engReady;

    assign busy    = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign done    = (state_q == ST_FINISH);
    assign overrun = overrun_q;

    // Frame sequencer. The next byte is offered on the same cycle as the
    // engine's byte-complete strobe so it loads without a gap on the line.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        wantByte = 1'b0;
        txByte   = SYNC_BYTE;
`ifdef FRAME_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SYNC;
                    shadow_d = data;
                    wantByte = 1'b1;
                    txByte   = SYNC_BYTE;
`ifdef FRAME_CHECKSUM_EN
                    csum_d   = '0;
`endif
                end
            end
            ST_SYNC: begin
                if (byteDone) begin
                    state_d  = ST_LEN;
                    wantByte = 1'b1;
                    txByte   = LEN_BYTE;
                end
            end
            ST_LEN: begin
                if (byteDone) begin
                    state_d  = ST_PAYLOAD;
                    idx_d    = '0;
                    wantByte = 1'b1;
                    txByte   = padded[7:0];
`ifdef FRAME_CHECKSUM_EN
                    csum_d   = csum_q ^ padded[7:0];
`endif
                end
            end
            ST_PAYLOAD: begin
                if (byteDone) begin
                    if (idx_q == IDX_LAST) begin
`ifdef FRAME_CHECKSUM_EN
                        state_d  = ST_CSUM;
                        wantByte = 1'b1;
                        txByte   = csum_q;
`else
                        state_d  = ST_FINISH;
`endif
                    end else begin
                        idx_d    = nxtIdx;
                        wantByte = 1'b1;
                        txByte   = nxtPayload;
`ifdef FRAME_CHECKSUM_EN
                        csum_d   = csum_q ^ nxtPayload;
`endif
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            ST_CSUM: begin
                if (byteDone) begin
                    state_d = ST_FINISH;
                end
            end
`endif
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers. A start while busy is dropped and flagged one
    // cycle later; FINISH does not count as busy, so no flag there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            shadow_q  <= '0;
            overrun_q <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            overrun_q <= start && busy;
`ifdef FRAME_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .byte_valid_i(byteValid),
        .byte_i      (txByte),
        .ready_o     (engReady),
        .byte_done_o (byteDone),
        .tx_o        (tx)
    );

endmodule
